udp_header_tx: RTL and testbench

UDP_HEADER_TX -- requirements
Module: udp_header_tx

---
 rtl/udp_header_tx.sv | 152 +++++++++++++++
 tb/tb_udp_header_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_header_tx.sv
// ---------------------------------------------------------------------------
// udp_header_tx
// Builds a UDP datagram on an 8-bit byte stream. It sends the 8-byte header
// (source port, destination port, length, zero checksum), then passes the
// payload bytes straight from the upstream source to the IP transmitter.
//
// Ports
//   aclk, areset            clock; asynchronous active-high reset
//   start                   one-cycle request to send one datagram
//   port_s, port_d          source / destination port, latched on accept
//   payload_len             payload byte count, latched on accept
//   s_data/s_valid/s_ready  upstream payload byte stream
//   data_out/data_valid/
//   data_ready/data_tlast   downstream UDP byte stream
//   busy                    a datagram is in flight
//   len_err                 one-cycle pulse when a start is rejected
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// HEADER  | sending header bytes 0..7 from the latched fields
// PAYLOAD | pass-through of payload bytes from s_* to data_*
// ---------------------------------------------------------------------------
module udp_header_tx #(
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic [15:0] port_s,
    input  logic [15:0] port_d,
    input  logic [10:0] payload_len,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_tlast,
    output logic        busy,
    output logic        len_err
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  hdr_cnt;
    logic [10:0] pay_cnt;
    logic [15:0] port_s_q;
    logic [15:0] port_d_q;
    logic [10:0] len_q;
    logic        len_err_q;

    logic        len_ok;
    logic        accept;
    logic        xfer;
    logic        hdr_last;
    logic        pay_last;
    logic [15:0] udp_len;

    assign len_ok   = (payload_len <= MAX_LEN);
    assign accept   = (state == IDLE) && start && len_ok;
    assign xfer     = data_valid && data_ready;
    assign hdr_last = (hdr_cnt == 3'd7);
    // len_q is at least 1 whenever PAYLOAD is entered, so len_q - 1 never wraps there.
    assign pay_last = (pay_cnt == (len_q - 11'd1));
    assign udp_len  = 16'(len_q) + 16'd8;
    assign busy     = (state != IDLE);
    assign len_err  = len_err_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        data_out   = 8'h00;
        data_valid = 1'b0;
        data_tlast = 1'b0;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                data_valid = 1'b1;
                case (hdr_cnt)
                    3'd0:    data_out = port_s_q[15:8];
                    3'd1:    data_out = port_s_q[7:0];
                    3'd2:    data_out = port_d_q[15:8];
                    3'd3:    data_out = port_d_q[7:0];
                    3'd4:    data_out = udp_len[15:8];
                    3'd5:    data_out = udp_len[7:0];
                    default: data_out = 8'h00;
                endcase
                data_tlast = hdr_last && (len_q == 11'd0);
                if (data_ready && hdr_last) begin
                    state_nxt = (len_q == 11'd0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                data_out   = s_data;
                data_valid = s_valid;
                s_ready    = data_ready;
                data_tlast = s_valid && pay_last;
                if (s_valid && data_ready && pay_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hdr_cnt   <= 3'd0;
            pay_cnt   <= 11'd0;
            port_s_q  <= 16'h0000;
            port_d_q  <= 16'h0000;
            len_q     <= 11'd0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= (state == IDLE) && start && !len_ok;
            if (accept) begin
                port_s_q <= port_s;
                port_d_q <= port_d;
                len_q    <= payload_len;
                hdr_cnt  <= 3'd0;
                pay_cnt  <= 11'd0;
            end else if (state == HEADER && xfer) begin
                hdr_cnt <= hdr_cnt + 3'd1;
            end else if (state == PAYLOAD && xfer) begin
                pay_cnt <= pay_cnt + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_header_tx.sv
module tb_udp_header_tx;

    logic        aclk        = 1'b0;
    logic        areset      = 1'b1;
    logic        start       = 1'b0;
    logic [15:0] port_s      = 16'h0000;
    logic [15:0] port_d      = 16'h0000;
    logic [10:0] payload_len = 11'd0;
    logic [7:0]  s_data      = 8'h00;
    logic        s_valid     = 1'b0;
    logic        s_ready;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready  = 1'b1;
    logic        data_tlast;
    logic        busy;
    logic        len_err;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];   // {tlast, byte}
    logic [7:0] src_q[$];
    logic [7:0] pay[$];
    logic       src_en      = 1'b1;
    logic       src_take    = 1'b0;
    logic       rand_mode   = 1'b0;
    logic       stall_hold  = 1'b0;
    logic [7:0] stall_byte  = 8'h00;
    logic       sready_seen = 1'b0;

    udp_header_tx #(.MAX_PAYLOAD(1472)) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .port_s(port_s), .port_d(port_d), .payload_len(payload_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .data_tlast(data_tlast), .busy(busy), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // downstream ready driver
    always @(posedge aclk) begin
        #1;
        data_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // upstream source model: presents src_q head, pops on consumption
    always begin
        @(negedge aclk);
        src_take = s_valid && s_ready;
        @(posedge aclk);
        #1;
        if (src_take && src_q.size() > 0) void'(src_q.pop_front());
        src_take = 1'b0;
        if (src_en && src_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
        end
    end

    // monitor: scoreboard pop on transfer, stability check while stalled
    always @(negedge aclk) begin
        if (areset) begin
            stall_hold = 1'b0;
        end else begin
            if (s_ready) sready_seen = 1'b1;
            if (stall_hold && data_valid) chk("stall_stable", 32'(data_out), 32'(stall_byte));
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'({data_tlast, data_out}), 32'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("byte", 32'({data_tlast, data_out}), 32'(e));
                end
            end
            stall_hold = data_valid && !data_ready;
            stall_byte = data_out;
        end
    end

    // Drives start at the current time, queues expectations, returns at the
    // negedge after the accept edge.
    task automatic send_start(input logic [15:0] ps, input logic [15:0] pd, input logic [10:0] len);
        logic [15:0] ul;
        logic [7:0]  hb[8];
        ul = 16'(len) + 16'd8;
        hb[0] = ps[15:8]; hb[1] = ps[7:0]; hb[2] = pd[15:8]; hb[3] = pd[7:0];
        hb[4] = ul[15:8]; hb[5] = ul[7:0]; hb[6] = 8'h00; hb[7] = 8'h00;
        start = 1'b1; port_s = ps; port_d = pd; payload_len = len;
        if (len <= 11'd1472) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({(len == 11'd0 && i == 7), hb[i]});
            for (int i = 0; i < pay.size(); i++) begin
                exp_q.push_back({(i == pay.size() - 1), pay[i]});
                src_q.push_back(pay[i]);
            end
        end
        @(posedge aclk);
        #1;
        start = 1'b0; port_s = 16'hDEAD; port_d = 16'hBEEF; payload_len = 11'd7;
        @(negedge aclk);
        if (len <= 11'd1472) begin
            chk("first_hdr_valid", 32'(data_valid), 32'd1);
            chk("busy_on_accept", 32'(busy), 32'd1);
        end
    endtask

    task automatic send(input logic [15:0] ps, input logic [15:0] pd, input logic [10:0] len);
        @(posedge aclk);
        #1;
        send_start(ps, pd, len);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk("frame_done_timeout", 32'(n >= budget), 32'd0);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_tlast", 32'(data_tlast), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        // basic datagram, one extra upstream byte left pending
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(16'h1234, 16'h0050, 11'd4);
        src_q.push_back(8'hEE);
        repeat (11) @(negedge aclk);
        chk("basic_last_byte", 32'(data_out), 32'hDD);
        chk("basic_tlast", 32'(data_tlast), 32'd1);
        chk("basic_busy_last", 32'(busy), 32'd1);
        @(negedge aclk);
        chk("basic_busy_after", 32'(busy), 32'd0);
        chk("basic_valid_after", 32'(data_valid), 32'd0);
        chk("extra_not_taken_rdy", 32'(s_ready), 32'd0);
        chk("extra_pending", 32'(src_q.size()), 32'd1);
        wait_done(100);
        src_q.delete();

        // random backpressure through header and payload
        rand_mode = 1'b1;
        pay = '{8'h01, 8'h80, 8'hFE, 8'h5A, 8'hA5, 8'h7F};
        send(16'hBEEF, 16'h1F90, 11'd6);
        wait_done(400);
        pay = '{8'hC3};
        send(16'h0000, 16'hFFFF, 11'd1);
        wait_done(200);
        rand_mode = 1'b0;

        // header-only datagram, upstream byte must stay untouched
        src_q.push_back(8'h77);
        @(posedge aclk);
        #2;
        sready_seen = 1'b0;
        pay.delete();
        send(16'h0001, 16'h0002, 11'd0);
        wait_done(100);
        chk("len0_sready_never", 32'(sready_seen), 32'd0);
        chk("len0_src_pending", 32'(src_q.size()), 32'd1);
        src_q.delete();

        // oversize rejection
        pay.delete();
        send(16'h4321, 16'h8765, 11'd1473);
        chk("rej_len_err", 32'(len_err), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_valid", 32'(data_valid), 32'd0);
        @(negedge aclk);
        chk("rej_len_err_1cyc", 32'(len_err), 32'd0);
        chk("rej_busy_2", 32'(busy), 32'd0);

        // largest accepted payload
        pay.delete();
        for (int i = 0; i < 1472; i++) pay.push_back(8'(i * 7));
        send(16'hCAFE, 16'h0801, 11'd1472);
        wait_done(3000);

        // start ignored while busy; back-to-back accept on the cycle busy falls
        src_en = 1'b0;
        pay = '{8'h31, 8'h32, 8'h33};
        send(16'h1111, 16'h2222, 11'd3);
        repeat (10) @(negedge aclk);
        @(posedge aclk);
        #1;
        start = 1'b1; port_s = 16'h9999; port_d = 16'h8888; payload_len = 11'd5;
        @(posedge aclk);
        #1;
        start = 1'b0;
        @(negedge aclk);
        chk("busy_start_no_err", 32'(len_err), 32'd0);
        chk("busy_start_busy", 32'(busy), 32'd1);
        @(posedge aclk);
        #1;
        start = 1'b1; port_s = 16'h3333; port_d = 16'h4444; payload_len = 11'd0;
        exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h44}); exp_q.push_back({1'b0, 8'h44});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b1, 8'h00});
        src_en = 1'b1;
        begin
            int n = 0;
            while (busy && n < 50) begin
                @(negedge aclk);
                n++;
            end
            chk("b2b_busy_fall_timeout", 32'(n >= 50), 32'd0);
        end
        chk("b2b_no_err", 32'(len_err), 32'd0);
        @(posedge aclk);
        #1;
        start = 1'b0;
        @(negedge aclk);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_valid", 32'(data_valid), 32'd1);
        wait_done(100);

        // reset mid-payload, then a clean datagram starting right at release
        pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        send(16'h5555, 16'h6666, 11'd6);
        repeat (10) @(negedge aclk);
        chk("pre_rst_byte", 32'(data_out), 32'h30);
        chk("pre_rst_valid", 32'(data_valid), 32'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(data_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_sready", 32'(s_ready), 32'd0);
        exp_q.delete();
        src_q.delete();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        pay = '{8'h9A, 8'hBC};
        send_start(16'hABCD, 16'h0035, 11'd2);
        wait_done(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
